// File: rtl/dcache_sram_nway.sv
// rtl/dcache_sram_nway.sv - N-way set-associative line storage with true-LRU ages and flush sequencer
module dcache_sram_nway #(
    parameter int SETS   = 16,
    parameter int WAYS   = 2,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    localparam int IDX_W = $clog2(SETS),
    localparam int AGE_W = $clog2(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              hit_o,
    output logic [LINE_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              valid_o,
    output logic              dirty_o,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [IDX_W-1:0]  wb_idx_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o,
    output logic              flush_done_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WB} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_set_q, ptr_set_d;
    logic [AGE_W-1:0]   ptr_way_q, ptr_way_d;
    logic               flush_done_q;
    logic               advance;
    logic               ptr_last;

    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]  data_q  [SETS][WAYS];
    logic               valid_q [SETS][WAYS];
    logic               dirty_q [SETS][WAYS];
    logic [AGE_W-1:0]   age_q   [SETS][WAYS];

    logic               hit_raw;
    logic               inv_found;
    logic [AGE_W-1:0]   hit_way, vic_way, sel_way, tgt_way, tgt_age;
    logic               access, commit_wr, promote, wb_hs;

    // Lowest index wins both for duplicate hits and for invalid-way victims.
    always_comb begin
        hit_raw   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vic_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_raw && valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
                hit_raw = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!inv_found && !valid_q[addr_i][w]) begin
                inv_found = 1'b1;
                vic_way   = AGE_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) begin
                    vic_way = AGE_W'(w);
                end
            end
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign hit_o        = hit_raw & ~busy_o;
    assign sel_way      = hit_o ? hit_way : vic_way;
    assign data_o       = data_q[addr_i][sel_way];
    assign tag_o        = tag_q[addr_i][sel_way];
    assign valid_o      = valid_q[addr_i][sel_way];
    assign dirty_o      = dirty_q[addr_i][sel_way];

    assign access       = enable_i & ~busy_o;
    assign commit_wr    = access & write_i;
    assign promote      = access & (write_i | hit_raw);
    assign tgt_way      = hit_raw ? hit_way : vic_way;
    assign tgt_age      = age_q[addr_i][tgt_way];

    assign wb_valid_o   = (state_q == ST_WB);
    assign wb_hs        = wb_valid_o & wb_ready_i;
    assign wb_idx_o     = ptr_set_q;
    assign wb_tag_o     = tag_q[ptr_set_q][ptr_way_q];
    assign wb_data_o    = data_q[ptr_set_q][ptr_way_q];
    assign flush_done_o = flush_done_q;

    assign ptr_last = (ptr_set_q == IDX_W'(SETS - 1)) && (ptr_way_q == AGE_W'(WAYS - 1));

    always_comb begin
        state_d   = state_q;
        ptr_set_d = ptr_set_q;
        ptr_way_d = ptr_way_q;
        advance   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d   = ST_SCAN;
                    ptr_set_d = '0;
                    ptr_way_d = '0;
                end
            end
            ST_SCAN: begin
                if (valid_q[ptr_set_q][ptr_way_q] && dirty_q[ptr_set_q][ptr_way_q]) begin
                    state_d = ST_WB;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WB: begin
                advance = wb_ready_i;
            end
            default: state_d = ST_IDLE;
        endcase
        // Way is the fast-moving pointer component, set the slow one.
        if (advance) begin
            if (ptr_last) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_SCAN;
                if (ptr_way_q == AGE_W'(WAYS - 1)) begin
                    ptr_way_d = '0;
                    ptr_set_d = ptr_set_q + IDX_W'(1);
                end else begin
                    ptr_way_d = ptr_way_q + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ptr_set_q    <= '0;
            ptr_way_q    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_set_q    <= ptr_set_d;
            ptr_way_q    <= ptr_way_d;
            flush_done_q <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
        end
    end

    // Accesses and write-back dirty clears never coincide: accesses are blocked while busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            if (promote) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == tgt_way) begin
                        age_q[addr_i][w] <= '0;
                    end else if (age_q[addr_i][w] < tgt_age) begin
                        age_q[addr_i][w] <= age_q[addr_i][w] + AGE_W'(1);
                    end
                end
            end
            if (commit_wr) begin
                tag_q[addr_i][tgt_way]   <= tag_i;
                data_q[addr_i][tgt_way]  <= data_i;
                valid_q[addr_i][tgt_way] <= 1'b1;
                dirty_q[addr_i][tgt_way] <= dirty_i;
            end
            if (wb_hs) begin
                dirty_q[ptr_set_q][ptr_way_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb/tb_dcache_sram_nway.sv - scoreboard bench for dcache_sram_nway (2-way and 4-way instances)
module tb_dcache_sram_nway;

    localparam int M_HIT = 1, M_VAL = 2, M_DIR = 4, M_TAG = 8, M_DAT = 16, M_ALL = 31;

    typedef struct packed {
        logic [7:0]   id;
        logic [4:0]   mask;
        logic         hit;
        logic         valid;
        logic         dirty;
        logic [22:0]  tag;
        logic [255:0] data;
    } rd_exp_t;

    typedef struct packed {
        logic [3:0]   idx;
        logic [22:0]  tag;
        logic [255:0] data;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] addr_a = '0, addr_b = '0;
    logic [22:0] tag_a = '0, tag_b = '0;
    logic [255:0] data_a = '0, data_b = '0;
    logic dirty_a = 0, dirty_b = 0, en_a = 0, en_b = 0, wr_a = 0, wr_b = 0;
    logic flush_a = 0, flush_b = 0, wb_ready_a = 0, wb_ready_b = 0;
    logic hit_a, hit_b, valid_oa, valid_ob, dirty_oa, dirty_ob;
    logic [255:0] data_oa, data_ob, wbdata_a, wbdata_b;
    logic [22:0] tag_oa, tag_ob, wbtag_a, wbtag_b;
    logic busy_a, busy_b, wbv_a, wbv_b, done_a, done_b;
    logic [3:0] wbidx_a, wbidx_b;

    dcache_sram_nway #(.SETS(16), .WAYS(2), .TAG_W(23), .LINE_W(256)) dut_a (
        .clk_i(clk), .rst_i(rst), .addr_i(addr_a), .tag_i(tag_a), .data_i(data_a),
        .dirty_i(dirty_a), .enable_i(en_a), .write_i(wr_a), .hit_o(hit_a),
        .data_o(data_oa), .tag_o(tag_oa), .valid_o(valid_oa), .dirty_o(dirty_oa),
        .flush_i(flush_a), .busy_o(busy_a), .wb_valid_o(wbv_a), .wb_ready_i(wb_ready_a),
        .wb_idx_o(wbidx_a), .wb_tag_o(wbtag_a), .wb_data_o(wbdata_a), .flush_done_o(done_a)
    );

    dcache_sram_nway #(.SETS(16), .WAYS(4), .TAG_W(23), .LINE_W(256)) dut_b (
        .clk_i(clk), .rst_i(rst), .addr_i(addr_b), .tag_i(tag_b), .data_i(data_b),
        .dirty_i(dirty_b), .enable_i(en_b), .write_i(wr_b), .hit_o(hit_b),
        .data_o(data_ob), .tag_o(tag_ob), .valid_o(valid_ob), .dirty_o(dirty_ob),
        .flush_i(flush_b), .busy_o(busy_b), .wb_valid_o(wbv_b), .wb_ready_i(wb_ready_b),
        .wb_idx_o(wbidx_b), .wb_tag_o(wbtag_b), .wb_data_o(wbdata_b), .flush_done_o(done_b)
    );

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0, done_cnt = 0, hs_cnt = 0;
    int stall_cfg = 0;
    rd_exp_t qa[$];
    rd_exp_t qb[$];
    wb_exp_t qw[$];

    localparam logic [22:0] TA = 23'h000100, TB = 23'h000200, TC = 23'h000300, TD = 23'h000400;
    localparam logic [22:0] TE = 23'h000500, TX = 23'h0ABC01, TY = 23'h0ABC02, TZ = 23'h0ABC03;
    localparam logic [22:0] TW = 23'h055555;

    function automatic logic [255:0] pat(input logic [31:0] s);
        return {8{s}};
    endfunction

    function automatic rd_exp_t ex(input logic [7:0] id, input int m, input logic h, input logic v,
                                   input logic d, input logic [22:0] t, input logic [255:0] dt);
        rd_exp_t e;
        e.id = id; e.mask = m[4:0]; e.hit = h; e.valid = v; e.dirty = d; e.tag = t; e.data = dt;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic check_rd(input rd_exp_t e, input logic h, input logic v, input logic d,
                            input logic [22:0] t, input logic [255:0] dt);
        if (e.mask[0]) cmp($sformatf("rd%0d_hit", e.id), h, e.hit);
        if (e.mask[1]) cmp($sformatf("rd%0d_valid", e.id), v, e.valid);
        if (e.mask[2]) cmp($sformatf("rd%0d_dirty", e.id), d, e.dirty);
        if (e.mask[3]) cmp($sformatf("rd%0d_tag", e.id), t, e.tag);
        if (e.mask[4]) cmp($sformatf("rd%0d_data", e.id), dt, e.data);
    endtask

    // Monitor: pops scoreboard entries whenever a read or a write-back offer is presented.
    initial begin
        rd_exp_t e;
        wb_exp_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (en_a && !wr_a) begin
                    if (qa.size() == 0) cmp("rd_a_unexpected", 1, 0);
                    else begin
                        e = qa.pop_front();
                        check_rd(e, hit_a, valid_oa, dirty_oa, tag_oa, data_oa);
                    end
                end
                if (en_b && !wr_b) begin
                    if (qb.size() == 0) cmp("rd_b_unexpected", 1, 0);
                    else begin
                        e = qb.pop_front();
                        check_rd(e, hit_b, valid_ob, dirty_ob, tag_ob, data_ob);
                    end
                end
                if (wbv_a) begin
                    if (qw.size() == 0) cmp("wb_unexpected", 1, 0);
                    else begin
                        w = qw[0];
                        cmp("wb_idx", wbidx_a, w.idx);
                        cmp("wb_tag", wbtag_a, w.tag);
                        cmp("wb_data", wbdata_a, w.data);
                        if (wb_ready_a) begin
                            void'(qw.pop_front());
                            hs_cnt++;
                        end
                    end
                end
                if (busy_a) busy_cnt++;
                if (done_a) done_cnt++;
            end
        end
    end

    // Write-back acceptor: stalls the first offer of each sweep by stall_cfg cycles.
    initial begin
        int low_run;
        low_run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy_a) low_run = 0;
            if (wbv_a) begin
                if (low_run < stall_cfg) begin
                    wb_ready_a = 1'b0;
                    low_run++;
                end else begin
                    wb_ready_a = 1'b1;
                end
            end else begin
                wb_ready_a = 1'b0;
            end
        end
    end

    task automatic rd_a(input logic [3:0] a, input logic [22:0] t, input rd_exp_t e);
        @(posedge clk); #1;
        addr_a = a; tag_a = t; wr_a = 1'b0; en_a = 1'b1;
        qa.push_back(e);
        @(posedge clk); #1;
        en_a = 1'b0;
    endtask

    task automatic wr_acc_a(input logic [3:0] a, input logic [22:0] t, input logic [255:0] d,
                            input logic dy);
        @(posedge clk); #1;
        addr_a = a; tag_a = t; data_a = d; dirty_a = dy; wr_a = 1'b1; en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0; wr_a = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] a, input logic [22:0] t, input rd_exp_t e);
        @(posedge clk); #1;
        addr_b = a; tag_b = t; wr_b = 1'b0; en_b = 1'b1;
        qb.push_back(e);
        @(posedge clk); #1;
        en_b = 1'b0;
    endtask

    task automatic wr_acc_b(input logic [3:0] a, input logic [22:0] t, input logic [255:0] d,
                            input logic dy);
        @(posedge clk); #1;
        addr_b = a; tag_b = t; data_b = d; dirty_b = dy; wr_b = 1'b1; en_b = 1'b1;
        @(posedge clk); #1;
        en_b = 1'b0; wr_b = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush_a = 1'b1;
        @(posedge clk); #1;
        flush_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_busy, base_done, base_hs;
        logic seen;
        #12;
        cmp("rst_busy", busy_a, 0);
        cmp("rst_wbv", wbv_a, 0);
        cmp("rst_done", done_a, 0);
        cmp("rst_valid", valid_oa, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset read and 2-way LRU eviction
        rd_a(4'd3, 23'h1A, ex(1, M_HIT | M_VAL | M_DIR, 0, 0, 0, 0, 0));
        cmp("idle_busy", busy_a, 0);
        wr_acc_a(4'd5, TA, pat(32'hA0A0_0001), 1'b1);
        wr_acc_a(4'd5, TB, pat(32'hB0B0_0002), 1'b0);
        rd_a(4'd5, TA, ex(2, M_ALL, 1, 1, 1, TA, pat(32'hA0A0_0001)));
        rd_a(4'd5, TC, ex(3, M_ALL, 0, 1, 0, TB, pat(32'hB0B0_0002)));
        wr_acc_a(4'd5, TC, pat(32'hC0C0_0003), 1'b0);
        rd_a(4'd5, TB, ex(4, M_ALL, 0, 1, 1, TA, pat(32'hA0A0_0001)));
        rd_a(4'd5, TA, ex(5, M_ALL, 1, 1, 1, TA, pat(32'hA0A0_0001)));

        // Write hit replaces data only in the hit way
        wr_acc_a(4'd5, TA, {256{1'b1}}, 1'b1);
        rd_a(4'd5, TA, ex(6, M_ALL, 1, 1, 1, TA, {256{1'b1}}));
        rd_a(4'd5, TC, ex(7, M_ALL, 1, 1, 0, TC, pat(32'hC0C0_0003)));

        // 4-way age ordering
        wr_acc_b(4'd0, TA, pat(32'h0000_000A), 1'b0);
        wr_acc_b(4'd0, TB, pat(32'h0000_000B), 1'b0);
        wr_acc_b(4'd0, TC, pat(32'h0000_000C), 1'b0);
        wr_acc_b(4'd0, TD, pat(32'h0000_000D), 1'b0);
        rd_b(4'd0, TB, ex(8, M_ALL, 1, 1, 0, TB, pat(32'h0000_000B)));
        rd_b(4'd0, TE, ex(9, M_ALL, 0, 1, 0, TA, pat(32'h0000_000A)));
        rd_b(4'd0, TA, ex(10, M_ALL, 1, 1, 0, TA, pat(32'h0000_000A)));
        rd_b(4'd0, TE, ex(11, M_ALL, 0, 1, 0, TC, pat(32'h0000_000C)));

        // Flush with a 3-cycle stall on the first offer
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        wr_acc_a(4'd2, TX, pat(32'h2222_0000), 1'b0);
        wr_acc_a(4'd2, TY, pat(32'h2222_0001), 1'b1);
        wr_acc_a(4'd9, TZ, pat(32'h9999_0000), 1'b1);
        qw.push_back({4'd2, TY, pat(32'h2222_0001)});
        qw.push_back({4'd9, TZ, pat(32'h9999_0000)});
        stall_cfg = 3;
        base_busy = busy_cnt; base_done = done_cnt; base_hs = hs_cnt;
        pulse_flush();
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        cmp("fl_done_seen", seen, 1);
        @(negedge clk);
        @(negedge clk);
        cmp("fl_busy_cycles", busy_cnt - base_busy, 37);
        cmp("fl_done_pulses", done_cnt - base_done, 1);
        cmp("fl_handshakes", hs_cnt - base_hs, 2);
        cmp("fl_wb_left", qw.size(), 0);
        rd_a(4'd2, TY, ex(12, M_ALL, 1, 1, 0, TY, pat(32'h2222_0001)));
        rd_a(4'd9, TZ, ex(13, M_ALL, 1, 1, 0, TZ, pat(32'h9999_0000)));
        rd_a(4'd2, TX, ex(14, M_ALL, 1, 1, 0, TX, pat(32'h2222_0000)));

        // Reset while a write-back is being offered
        stall_cfg = 1000;
        wr_acc_a(4'd4, TW, pat(32'h4444_0000), 1'b1);
        qw.push_back({4'd4, TW, pat(32'h4444_0000)});
        base_done = done_cnt;
        pulse_flush();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (wbv_a) seen = 1'b1;
        end
        cmp("rwb_offer_seen", seen, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        cmp("rwb_wbv", wbv_a, 0);
        cmp("rwb_busy", busy_a, 0);
        cmp("rwb_done", done_a, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        qw.delete();
        stall_cfg = 0;
        for (int s = 0; s < 16; s++) begin
            rd_a(4'(s), TW, ex(8'(20 + s), M_HIT | M_VAL | M_DIR, 0, 0, 0, 0, 0));
        end
        cmp("rwb_no_done", done_cnt - base_done, 0);
        cmp("rd_a_left", qa.size(), 0);
        cmp("rd_b_left", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
